uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares one UART `transmitter` among `NREQ` byte sources. It accepts bytes over per-requester valid/ready handshakes and loads the transmitter one frame at a time through `din`/`wr_en`. It waits out each frame using `tx_busy`, and generates the transmitter's `txclken` baud tick from the system clock. It sits between the producer blocks and the single `transmitter` instance.

## Interface
- `NREQ`, 4: number of requesters; range 2..8.
- `CLK_DIV`, 16: `clk` cycles per `tx_clken` pulse; minimum 2.
- `clk`  in  1: system clock; also drives the transmitter's `txclk`.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i high means requester i has a byte to send.
- `req_data`  in  8*NREQ: byte of requester i is at `[8*i+7:8*i]`.
- `req_ready`  out  NREQ: one-hot accept strobe. A byte is taken on the edge where `req_valid[i]` and `req_ready[i]` are both high.
- `tx_din`  out  8: byte to the transmitter's `din`.
- `tx_wr_en`  out  1: one-cycle load strobe to the transmitter's `wr_en`.
- `tx_clken`  out  1: baud tick to the transmitter's `txclken`.
- `tx_busy`  in  1: from the transmitter; high while a frame is shifting.
- `grant_id`  out  $clog2(NREQ): index of the last accepted requester.
- `active`  out  1: high from accept until the frame completes.

## Operation
- **Baud divider**
  - Free-running counter `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `tx_clken` = 1 exactly when `div_cnt == CLK_DIV-1`, so it pulses once per `CLK_DIV` cycles.
  - The divider runs in every FSM state.
- **FSM states:** IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `tx_busy`=0 and any `req_valid` bit is set, arbitrate round-robin. The search starts at `(last_grant+1) mod NREQ` and wraps; the first valid index wins.
  - `req_ready[winner]`=1 combinationally in this cycle; all other `req_ready` bits are 0.
  - On the edge: capture `req_data[winner]` into `hold`, set `last_grant`=`grant_id`=winner, go to LOAD.
  - If no request, or `tx_busy`=1, stay in IDLE with `req_ready`=0.
- **LOAD:** `tx_wr_en`=1 and `tx_din`=`hold` for exactly one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay until `tx_busy`=1, then go to WAIT_DONE. `tx_wr_en` is not reasserted.
- **WAIT_DONE:** stay until `tx_busy`=0, then go to IDLE.
- **`active` and `tx_din`**
  - `active`=1 in LOAD, WAIT_BUSY and WAIT_DONE; 0 in IDLE.
  - `tx_din` holds `hold` in every state except reset.
- **Priority:** the requester granted most recently has the lowest priority on the next arbitration. A requester that holds `req_valid` continuously is served within `NREQ` frames.
- **req_valid dropping:** if `req_valid[i]` falls in IDLE before it wins, there is no accept and no side effect.
- **Reset**
  - Asynchronous; takes effect immediately.
  - State = IDLE, `div_cnt`=0, `hold`=0, `last_grant`=NREQ-1 (requester 0 wins first), `grant_id`=0.
  - All outputs are 0: `req_ready`, `tx_din`, `tx_wr_en`, `tx_clken`, `active`.
  - Reset mid-frame abandons the frame with no retry. The transmitter is not reset by this block; after reset the FSM waits in IDLE until `tx_busy`=0.

## Timing
- The accept edge is cycle 0. `tx_wr_en` is high in cycle 1, and WAIT_BUSY begins in cycle 2.
- Earliest next accept is the first IDLE cycle after `tx_busy` falls, i.e. 1 cycle after the falling edge is sampled.
- No combinational path from `tx_busy` to `tx_wr_en`. `req_ready` depends combinationally on `req_valid`, `tx_busy` and state only.
- The `tx_clken` period is exactly `CLK_DIV` cycles and is not phase-aligned to `tx_wr_en`.
- Throughput: at most one byte per transmitter frame. No buffering beyond the one-byte `hold`.

## Test plan
- **Single request:** after reset, `req_valid`=4'b0001 with byte 8'h63 → `req_ready[0]` high for 1 cycle. Next cycle `tx_wr_en`=1 and `tx_din`=8'h63; `grant_id`=0. Shifted-out `tx` bits decode to 8'h63.
- **Round-robin:** all four requesters hold valid with bytes 8'hA0..8'hA3 → frames go out in order 0,1,2,3,0. Exactly one `req_ready` bit per frame; no new `tx_wr_en` while `tx_busy`=1.
- **Priority rotation:** grant 2, then `req_valid`=4'b0101 → next grant is 0 (search starts at 3, wraps past 3 to 0), not 2.
- **Divider:** `CLK_DIV`=16 → `tx_clken` pulses 1 cycle in every 16, first at cycle 15 after reset release; cadence is unchanged while frames are sent.
- **Busy gating:** force `tx_busy`=1 with requests pending → `req_ready` stays 0. Release `tx_busy` → accept in the next cycle.
- **Reset mid-frame:** assert `rst` during WAIT_DONE → all outputs 0 immediately and `last_grant` is restored. After release, requester 0 wins first once `tx_busy`=0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter among NREQ byte sources.
// Each source offers a byte over a valid/ready handshake. The winner's byte is
// captured into a one-byte hold register and loaded into the transmitter with
// a single-cycle wr_en strobe. The scheduler then waits for the transmitter's
// busy flag to rise and fall before arbitrating again. A free-running divider
// generates the transmitter's baud tick from the system clock.

module uart_tx_sched #(
   parameter int NREQ    = 4,
   parameter int CLK_DIV = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [8*NREQ-1:0]        req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [7:0]               tx_din,
   output logic                     tx_wr_en,
   output logic                     tx_clken,
   input  logic                     tx_busy,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     active
);

   // Width of a requester index, of the wrap-around search sum, and of the divider.
   localparam int GW = $clog2(NREQ);
   localparam int SW = GW + 1;
   localparam int CW = $clog2(CLK_DIV);

   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GRANT_INIT = GW'(NREQ - 1);
   localparam logic [SW-1:0] NREQ_S     = SW'(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t          state_r;
   logic [7:0]      hold_r;
   logic [GW-1:0]   last_grant_r;
   logic [GW-1:0]   grant_id_r;
   logic            wr_en_r;
   logic            active_r;
   logic [CW-1:0]   div_cnt_r;
   logic [CW-1:0]   div_next_s;
   logic            clken_r;

   logic [SW-1:0]   cand_s;
   logic [GW-1:0]   win_idx_s;
   logic            win_found_s;
   logic            grant_ok_s;
   logic [NREQ-1:0] ready_s;

   // Next value of the baud divider: counts 0..CLK_DIV-1 and wraps.
   always_comb begin
      div_next_s = div_cnt_r;
      if (div_cnt_r == DIV_LAST) begin
         div_next_s = {CW{1'b0}};
      end else begin
         div_next_s = div_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Free-running divider; the tick register mirrors div_cnt == CLK_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r <= {CW{1'b0}};
         clken_r   <= 1'b0;
      end else begin
         div_cnt_r <= div_next_s;
         clken_r   <= (div_next_s == DIV_LAST);
      end
   end

   // Round-robin search starting just after the last grant, wrapping at NREQ.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {GW{1'b0}};
      cand_s      = {SW{1'b0}};
      for (int i = 1; i <= NREQ; i++) begin
         cand_s = {1'b0, last_grant_r} + SW'(i);
         if (cand_s >= NREQ_S) begin
            cand_s = cand_s - NREQ_S;
         end else begin
            cand_s = cand_s;
         end
         if (!win_found_s && req_valid[cand_s[GW-1:0]]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s[GW-1:0];
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Accept is only possible in IDLE with the transmitter idle; ready is one-hot.
   always_comb begin
      ready_s    = {NREQ{1'b0}};
      grant_ok_s = (state_r == ST_IDLE) && !tx_busy && win_found_s;
      if (grant_ok_s) begin
         ready_s[win_idx_s] = 1'b1;
      end else begin
         ready_s = {NREQ{1'b0}};
      end
   end

   // Scheduler FSM: accept, load for one cycle, wait for busy to rise then fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         hold_r       <= 8'h00;
         last_grant_r <= GRANT_INIT;
         grant_id_r   <= {GW{1'b0}};
         wr_en_r      <= 1'b0;
         active_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_ok_s) begin
                  hold_r       <= req_data[{win_idx_s, 3'b000} +: 8];
                  last_grant_r <= win_idx_s;
                  grant_id_r   <= win_idx_s;
                  wr_en_r      <= 1'b1;
                  active_r     <= 1'b1;
                  state_r      <= ST_LOAD;
               end else begin
                  wr_en_r      <= 1'b0;
                  active_r     <= 1'b0;
               end
            end
            ST_LOAD: begin
               // The strobe lasts exactly one cycle regardless of tx_busy.
               wr_en_r  <= 1'b0;
               active_r <= 1'b1;
               state_r  <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               wr_en_r  <= 1'b0;
               active_r <= 1'b1;
               if (tx_busy) begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               wr_en_r <= 1'b0;
               if (!tx_busy) begin
                  active_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else begin
                  active_r <= 1'b1;
               end
            end
            default: begin
               wr_en_r  <= 1'b0;
               active_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_s;
   assign tx_din    = hold_r;
   assign tx_wr_en  = wr_en_r;
   assign tx_clken  = clken_r;
   assign grant_id  = grant_id_r;
   assign active    = active_r;

endmodule
